// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans Cont/Pc/led onto a 4-digit active-low 7-segment display.
// Every digit slot is preceded by a blank slot, and all three inputs are snapshotted once per frame.
module seg_scan_driver #(
  parameter int SCAN_DIV = 16
) (
  input  logic       fastclk,
  input  logic       rst,
  input  logic [3:0] Cont,
  input  logic [3:0] Pc,
  input  logic       led,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_pulse
);
  localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic {BLANK, DRIVE} phase_t;
  phase_t      phase, phase_nxt;
  logic [1:0]  d, d_nxt;
  logic [15:0] pre;
  logic [3:0]  sh_cont, sh_pc, cont_v, pc_v, digit, an_nxt;
  logic [6:0]  seg_nxt;
  logic        sh_led, led_v, tick, snap, dark;
  // Outputs are registered from the next state, so the snapshot taken on the
  // tick that leaves BLANK(0) is bypassed straight into the DRIVE(0) digit.
  always_comb begin
    tick      = pre == LAST;
    snap      = tick && phase == BLANK && d == 2'd0;
    phase_nxt = tick ? (phase == BLANK ? DRIVE : BLANK) : phase;
    d_nxt     = (tick && phase == DRIVE) ? d + 2'd1 : d;
    cont_v    = snap ? Cont : sh_cont;
    pc_v      = snap ? Pc : sh_pc;
    led_v     = snap ? led : sh_led;
    digit     = d_nxt == 2'd0 ? cont_v : d_nxt == 2'd1 ? pc_v : {3'b0, led_v};
    dark      = phase_nxt == BLANK || d_nxt == 2'd3;
    an_nxt    = dark ? 4'hF : ~(4'b0001 << d_nxt);
    seg_nxt   = dark ? 7'h7F : HEX[digit];
  end
  always_ff @(posedge fastclk or negedge rst)
    if (!rst) begin
      pre   <= '0;
      phase <= BLANK;
      d     <= '0;
    end else begin
      pre   <= tick ? '0 : pre + 16'd1;
      phase <= phase_nxt;
      d     <= d_nxt;
    end
  always_ff @(posedge fastclk or negedge rst)
    if (!rst) {sh_cont, sh_pc, sh_led} <= '0;
    else if (snap) {sh_cont, sh_pc, sh_led} <= {Cont, Pc, led};
  always_ff @(posedge fastclk or negedge rst)
    if (!rst) begin
      an          <= 4'hF;
      seg         <= 7'h7F;
      frame_pulse <= 1'b0;
    end else begin
      an          <= an_nxt;
      seg         <= seg_nxt;
      frame_pulse <= snap;
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: checks SCAN_DIV=4 and SCAN_DIV=1 builds against a slot-arithmetic model.
module tb_seg_scan_driver;
  logic       fastclk = 1'b0, rst = 1'b0;
  logic [3:0] Cont = '0, Pc = '0;
  logic       led = 1'b0;
  logic [3:0] an4, an1;
  logic [6:0] seg4, seg1;
  logic       fp4, fp1;
  int         tests = 0, fails = 0;
  int         n = 0;
  logic [8:0] sh4 = '0, sh1 = '0;
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 fastclk = ~fastclk;

  seg_scan_driver #(.SCAN_DIV(4)) u4 (.fastclk(fastclk), .rst(rst), .Cont(Cont), .Pc(Pc), .led(led),
                                      .an(an4), .seg(seg4), .frame_pulse(fp4));
  seg_scan_driver #(.SCAN_DIV(1)) u1 (.fastclk(fastclk), .rst(rst), .Cont(Cont), .Pc(Pc), .led(led),
                                      .an(an1), .seg(seg1), .frame_pulse(fp1));

  // n = rising edges since reset release; a snapshot happens when the tick count hits 1 mod 8
  always @(posedge fastclk or negedge rst)
    if (!rst) begin
      n   <= 0;
      sh4 <= '0;
      sh1 <= '0;
    end else begin
      n <= n + 1;
      if ((n + 1) % 4 == 0 && ((n + 1) / 4) % 8 == 1) sh4 <= {Cont, Pc, led};
      if ((n + 1) % 8 == 1) sh1 <= {Cont, Pc, led};
    end

  function automatic logic [11:0] model(int div, int cyc, logic [8:0] sh);
    int k, dd;
    logic fp;
    logic [3:0] v;
    k  = cyc / div;
    dd = (k / 2) % 4;
    fp = cyc > 0 && cyc % div == 0 && k % 8 == 1;
    v  = dd == 0 ? sh[8:5] : dd == 1 ? sh[4:1] : {3'b0, sh[0]};
    if (k % 2 == 0 || dd == 3) return {4'hF, 7'h7F, fp};
    return {~(4'b0001 << dd), HEX[v], fp};
  endfunction

  task automatic restart(input logic [3:0] c, input logic [3:0] p, input logic l);
    rst = 1'b0;
    repeat (2) @(negedge fastclk);
    Cont = c; Pc = p; led = l;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    Cont = 4'($urandom); Pc = 4'($urandom); led = 1'($urandom);
    repeat (3) @(negedge fastclk);
    tests++;
    if ({an4, seg4, fp4} !== {4'hF, 7'h7F, 1'b0}) begin
      fails++; $display("FAIL reset4 got %h want %h", {an4, seg4, fp4}, {4'hF, 7'h7F, 1'b0});
    end
    tests++;
    if ({an1, seg1, fp1} !== {4'hF, 7'h7F, 1'b0}) begin
      fails++; $display("FAIL reset1 got %h want %h", {an1, seg1, fp1}, {4'hF, 7'h7F, 1'b0});
    end
  endtask

  task automatic test_frame;
    logic [11:0] e4, e1;
    restart(4'd4, 4'd2, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      @(negedge fastclk);
      e4 = model(4, n, sh4); e1 = model(1, n, sh1);
      tests++;
      if ({an4, seg4, fp4} !== e4) begin fails++; $display("FAIL frame4 n=%0d got %h want %h", n, {an4, seg4, fp4}, e4); end
      tests++;
      if ({an1, seg1, fp1} !== e1) begin fails++; $display("FAIL frame1 n=%0d got %h want %h", n, {an1, seg1, fp1}, e1); end
      if (i == 4) begin
        tests++;
        if ({an4, seg4, fp4} !== {4'b1110, 7'b0011001, 1'b1}) begin
          fails++; $display("FAIL drive0 got %b_%b_%b want 1110_0011001_1", an4, seg4, fp4);
        end
      end
      if (i == 5) begin
        tests++;
        if (fp4 !== 1'b0) begin fails++; $display("FAIL pulse_width got %b want 0", fp4); end
      end
      if (i == 12) begin
        tests++;
        if ({an4, seg4} !== {4'b1101, 7'b0100100}) begin
          fails++; $display("FAIL drive1 got %b_%b want 1101_0100100", an4, seg4);
        end
      end
      if (i == 20) begin
        tests++;
        if ({an4, seg4} !== {4'b1011, 7'b1000000}) begin
          fails++; $display("FAIL drive2 got %b_%b want 1011_1000000", an4, seg4);
        end
      end
      if (i == 28) begin
        tests++;
        if (an4 !== 4'b1111) begin fails++; $display("FAIL drive3 got %b want 1111", an4); end
      end
    end
  endtask

  task automatic test_snapshot;
    logic [11:0] e4;
    restart(4'd4, 4'd7, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      @(negedge fastclk);
      e4 = model(4, n, sh4);
      tests++;
      if ({an4, seg4, fp4} !== e4) begin fails++; $display("FAIL snap n=%0d got %h want %h", n, {an4, seg4, fp4}, e4); end
      if (i == 13) Cont = 4'd2;
      if (i == 36) begin
        tests++;
        if (seg4 !== 7'b0100100) begin fails++; $display("FAIL next_frame got %b want 0100100", seg4); end
      end
    end
  endtask

  task automatic test_random_blank;
    logic [11:0] e4, e1;
    int last4;
    last4 = -1;
    restart(4'($urandom), 4'($urandom), 1'($urandom));
    for (int i = 1; i <= 200; i++) begin
      @(negedge fastclk);
      e4 = model(4, n, sh4); e1 = model(1, n, sh1);
      tests++;
      if ({an4, seg4, fp4} !== e4) begin fails++; $display("FAIL rand4 n=%0d got %h want %h", n, {an4, seg4, fp4}, e4); end
      tests++;
      if ({an1, seg1, fp1} !== e1) begin fails++; $display("FAIL rand1 n=%0d got %h want %h", n, {an1, seg1, fp1}, e1); end
      if ((n / 4) % 2 == 0) begin
        tests++;
        if ({an4, seg4} !== {4'hF, 7'h7F}) begin fails++; $display("FAIL blank n=%0d got %h", n, {an4, seg4}); end
      end
      if (fp4) begin
        if (last4 >= 0) begin
          tests++;
          if (n - last4 != 32) begin fails++; $display("FAIL period4 got %0d want 32", n - last4); end
        end
        last4 = n;
      end
      if ($urandom_range(3) == 0) Cont = 4'($urandom);
      if ($urandom_range(3) == 0) Pc = 4'($urandom);
      if ($urandom_range(3) == 0) led = 1'($urandom);
    end
  endtask

  task automatic test_led_pc;
    logic [11:0] e4;
    restart(4'($urandom), 4'd15, 1'b1);
    for (int i = 1; i <= 24; i++) begin
      @(negedge fastclk);
      e4 = model(4, n, sh4);
      tests++;
      if ({an4, seg4, fp4} !== e4) begin fails++; $display("FAIL ledpc n=%0d got %h want %h", n, {an4, seg4, fp4}, e4); end
      if (i == 12) begin
        tests++;
        if (seg4 !== 7'b0001110) begin fails++; $display("FAIL pc15 got %b want 0001110", seg4); end
      end
      if (i == 20) begin
        tests++;
        if (seg4 !== 7'b1111001) begin fails++; $display("FAIL led1 got %b want 1111001", seg4); end
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [11:0] e4;
    int guard;
    guard = 0;
    restart(4'($urandom), 4'($urandom), 1'b1);
    while (n != 21 && guard < 100) begin @(negedge fastclk); guard++; end
    tests++;
    if (n != 21) begin fails++; $display("FAIL midrst_reach got n=%0d want 21", n); end
    @(posedge fastclk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({an4, seg4, fp4} !== {4'hF, 7'h7F, 1'b0}) begin fails++; $display("FAIL async4 got %h", {an4, seg4, fp4}); end
    tests++;
    if ({an1, seg1, fp1} !== {4'hF, 7'h7F, 1'b0}) begin fails++; $display("FAIL async1 got %h", {an1, seg1, fp1}); end
    @(negedge fastclk);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge fastclk);
      e4 = model(4, n, sh4);
      tests++;
      if ({an4, seg4, fp4} !== e4) begin fails++; $display("FAIL rerun n=%0d got %h want %h", n, {an4, seg4, fp4}, e4); end
      if (i == 4) begin
        tests++;
        if ({an4, fp4} !== {4'b1110, 1'b1}) begin fails++; $display("FAIL restart got %b_%b want 1110_1", an4, fp4); end
      end
    end
  endtask

  task automatic test_div1;
    logic [11:0] e1;
    int last1;
    last1 = -1;
    restart(4'($urandom), 4'($urandom), 1'($urandom));
    for (int i = 1; i <= 40; i++) begin
      @(negedge fastclk);
      e1 = model(1, n, sh1);
      tests++;
      if ({an1, seg1, fp1} !== e1) begin fails++; $display("FAIL div1 n=%0d got %h want %h", n, {an1, seg1, fp1}, e1); end
      if (i == 1 || i == 3) begin
        tests++;
        if (an1 !== (i == 1 ? 4'b1110 : 4'b1101)) begin fails++; $display("FAIL div1_an i=%0d got %b", i, an1); end
      end
      if (fp1) begin
        if (last1 >= 0) begin
          tests++;
          if (n - last1 != 8) begin fails++; $display("FAIL period1 got %0d want 8", n - last1); end
        end
        last1 = n;
      end
      Cont = 4'($urandom); Pc = 4'($urandom); led = 1'($urandom);
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_snapshot;
    test_random_blank;
    test_led_pc;
    test_mid_reset;
    test_div1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16, meaning clock cycles per scan slot; legal range 1..65536.
REQ-002 SHALL have port fastclk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Cont  input  4  counter value from Top, shown as a hex digit.
REQ-005 SHALL have port Pc  input  4  program counter from Top, shown as a hex digit.
REQ-006 SHALL have port led  input  1  LED status from Top, shown as digit 0/1.
REQ-007 SHALL have port an  output  4  digit anodes, active-low, an[0] = digit 0.
REQ-008 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port frame_pulse  output  1  one-cycle strobe when a new input snapshot is taken.

Function
REQ-010 SHALL hold a prescaler counting 0..SCAN_DIV-1 and wrapping; tick = prescaler at SCAN_DIV-1.
REQ-011 SHALL run an FSM of two phases, BLANK and DRIVE, plus a 2-bit digit index d; it advances only on tick.
REQ-012 SHALL sequence BLANK(d) -> DRIVE(d) -> BLANK(d+1), with d wrapping 3 -> 0; frame = 8*SCAN_DIV cycles.
REQ-013 SHALL drive an = 4'b1111 and seg = 7'b1111111 during every BLANK slot (anti-ghosting).
REQ-014 SHALL load shadow registers {Cont, Pc, led} on the tick leaving BLANK(0), and pulse frame_pulse high for exactly that following cycle.
REQ-015 SHALL display only shadow values; input changes mid-frame are not shown until the next snapshot.
REQ-016 SHALL drive DRIVE(0): an=1110, seg=hex(Cont); DRIVE(1): an=1101, seg=hex(Pc); DRIVE(2): an=1011, seg=hex({3'b0,led}).
REQ-017 SHALL drive DRIVE(3) as unused: an=1111, seg=1111111.
REQ-018 SHALL register an, seg and frame_pulse, updating on the same edge as the FSM transition.
REQ-019 SHALL decode hex 0..F as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-020 SHALL, with SCAN_DIV=1, tick every cycle, so each slot lasts one cycle.
REQ-021 SHALL size the prescaler at 16 bits and never let it exceed SCAN_DIV-1.

Reset
REQ-022 SHALL, while rst=0, force prescaler=0, phase=BLANK, d=0, shadow=0, an=1111, seg=1111111, frame_pulse=0, irrespective of fastclk.
REQ-023 SHALL, after rst deasserts, take the first tick SCAN_DIV rising edges later and enter DRIVE(0) with a fresh snapshot.
REQ-024 SHALL, on reset asserted mid-frame, abort the frame immediately; the restart follows REQ-023.

Verification (SCAN_DIV=4)
REQ-025 SHALL test: reset, then Cont=4, Pc=2, led=0 -> 4 cycles after release an=1110, seg=0011001, frame_pulse high 1 cycle; 8 cycles later an=1101, seg=0100100; 8 more an=1011, seg=1000000; 8 more an=1111.
REQ-026 SHALL test: Cont changes 4 -> 2 during DRIVE(1) -> DRIVE(0) of the current frame stays 0011001; the next frame shows 0100100.
REQ-027 SHALL test: in every BLANK slot, an=1111 and seg=1111111; frame_pulse period = 32 cycles exactly.
REQ-028 SHALL test: led=1, Pc=15 -> DRIVE(1) seg=0001110, DRIVE(2) seg=1111001.
REQ-029 SHALL test: rst pulsed low during DRIVE(2) -> outputs are at reset values within the same cycle; DRIVE(0) occurs 4 cycles after release.
REQ-030 SHALL test: SCAN_DIV=1 build -> slot advances every cycle; frame_pulse period = 8 cycles.
